pipelined_ripple_adder: RTL and testbench

Parametrised N-bit carry-ripple adder/subtractor, split into S = N/SEG ripple segments with one register stage per segment. Throughput is one operation per clock; latency is S cycles. Valid/ready handshakes sit on both sides. The block is the pipelined successor to the team's combinational ripple adder and is meant for wide datapaths where a full-width ripple misses timing.

---
 rtl/pipelined_ripple_adder.sv | 139 +++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// Pipelined N-bit carry-ripple adder: one SEG-bit ripple segment per stage, valid/ready on both sides.
// Optional subtract mode (sub port) is built when PIPE_ADDER_SUB_EN is defined.
module pipelined_ripple_adder #(
  parameter int unsigned N   = 64,
  parameter int unsigned SEG = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned S = N / SEG;

  logic         en;
  logic [N-1:0] b_eff;
  logic         c_eff;

`ifdef PIPE_ADDER_SUB_EN
  // a - b is a + ~b + 1; cin is absorbed by the forced carry-in.
  assign b_eff = b ^ {N{sub}};
  assign c_eff = cin | sub;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  // Plain bit-serial ripple over one segment; returns {carry_out, sum}.
  function automatic logic [SEG:0] ripple(input logic [SEG-1:0] x,
                                          input logic [SEG-1:0] y,
                                          input logic           c_in);
    logic [SEG:0]   c;
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] s;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      s[i]   = p[i] ^ c[i];
    end
    return {c[SEG], s};
  endfunction

  genvar k;
  generate
    for (k = 0; k < S; k++) begin : g_stage
      logic                  valid_r;
      logic                  carry_r;
      logic [(k+1)*SEG-1:0]  sum_r;
      logic [SEG-1:0]        seg_a;
      logic [SEG-1:0]        seg_b;
      logic                  seg_cin;
      logic                  valid_nxt;
      logic [SEG:0]          seg_res;
      logic [(k+1)*SEG-1:0]  sum_nxt;

      if (k == 0) begin : g_src
        assign seg_a     = a[SEG-1:0];
        assign seg_b     = b_eff[SEG-1:0];
        assign seg_cin   = c_eff;
        assign valid_nxt = in_valid;
      end else begin : g_src
        assign seg_a     = g_stage[k-1].g_opnd.a_r[SEG-1:0];
        assign seg_b     = g_stage[k-1].g_opnd.b_r[SEG-1:0];
        assign seg_cin   = g_stage[k-1].carry_r;
        assign valid_nxt = g_stage[k-1].valid_r;
      end

      assign seg_res = ripple(seg_a, seg_b, seg_cin);

      // New segment lands above the sum bits already resolved upstream.
      if (k == 0) begin : g_sum
        assign sum_nxt = seg_res[SEG-1:0];
      end else begin : g_sum
        assign sum_nxt = {seg_res[SEG-1:0], g_stage[k-1].sum_r};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r <= 1'b0;
          carry_r <= 1'b0;
          sum_r   <= '0;
        end else if (en) begin
          valid_r <= valid_nxt;
          carry_r <= seg_res[SEG];
          sum_r   <= sum_nxt;
        end
      end

      // Operand bits not yet consumed; the last stage has none left.
      if (k < S - 1) begin : g_opnd
        logic [N-(k+1)*SEG-1:0] a_r;
        logic [N-(k+1)*SEG-1:0] b_r;
        logic [N-(k+1)*SEG-1:0] a_nxt;
        logic [N-(k+1)*SEG-1:0] b_nxt;

        if (k == 0) begin : g_fwd
          assign a_nxt = a[N-1:SEG];
          assign b_nxt = b_eff[N-1:SEG];
        end else begin : g_fwd
          assign a_nxt = g_stage[k-1].g_opnd.a_r[N-k*SEG-1:SEG];
          assign b_nxt = g_stage[k-1].g_opnd.b_r[N-k*SEG-1:SEG];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            a_r <= '0;
            b_r <= '0;
          end else if (en) begin
            a_r <= a_nxt;
            b_r <= b_nxt;
          end
        end
      end
    end
  endgenerate

  // One global enable: the whole pipe advances unless the tail is blocked.
  assign out_valid = g_stage[S-1].valid_r;
  assign sum       = g_stage[S-1].sum_r;
  assign cout      = g_stage[S-1].carry_r;
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder (N=64, SEG=16): queue-based arithmetic model plus directed literal checks.
// Build with PIPE_ADDER_SUB_EN defined to also exercise subtract mode.
module tb_pipelined_ripple_adder;

  localparam int unsigned N  = 64;
  localparam int unsigned S  = 4;
  localparam int unsigned W1 = N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         cout;

  pipelined_ripple_adder #(.N(64), .SEG(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stall = -1;

  typedef struct {
    logic [N:0] val;
    int         acc;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  bit         prev_stall = 1'b0;
  logic [N:0] prev_res;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact 65-bit reference result from plain arithmetic.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic c, input logic s);
    logic [N-1:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + W1'(1);
    return {1'b0, x} + {1'b0, y} + W1'(c);
  endfunction

  // Compare process: evaluated mid-cycle, describing the transfers of the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_stall = cyc;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", W1'(out_valid), W1'(1));
        check("stall_hold", {cout, sum}, prev_res);
      end
      check("in_ready_rule", W1'(in_ready), W1'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %h expected no result (cycle %0d)", {cout, sum}, cyc);
        end else begin
          e = q.pop_front();
          check("result", {cout, sum}, e.val);
          if (e.acc > last_stall) check("latency", W1'(cyc - e.acc), W1'(S));
        end
      end
      if (out_valid && !out_ready) last_stall = cyc;
      prev_stall = out_valid && !out_ready;
      prev_res   = {cout, sum};
      if (in_valid && in_ready) begin
        e.val = model(a, b, cin, sub);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    a   = {$urandom(), $urandom()};
    b   = {$urandom(), $urandom()};
    cin = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) a = '1;
    if ($urandom_range(0, 7) == 0) b = ~a;
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    check("drain_empty", W1'(q.size()), W1'(0));
  endtask

  task automatic single(input logic [N-1:0] xa, input logic [N-1:0] xb,
                        input logic xc, input logic xs,
                        input logic [N:0] expv, input string name);
    a = xa; b = xb; cin = xc; sub = xs;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check({name, "_early"}, W1'(out_valid), W1'(0));
    step();
    check({name, "_valid"}, W1'(out_valid), W1'(1));
    check({name, "_value"}, {cout, sum}, expv);
    step();
  endtask

  initial begin
    int sent;
    int fill;
    bit acc;

    // Reset and idle behaviour
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", W1'(out_valid), W1'(0));
    check("rst_sum", W1'(sum), W1'(0));
    check("rst_cout", W1'(cout), W1'(0));
    check("rst_in_ready", W1'(in_ready), W1'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      check("idle_no_out", W1'(out_valid), W1'(0));
    end

    // Carry ripples through all four segments
    single(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 65'h1_0000_0000_0000_0000, "carry_all");
    single(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
           65'h1_0000_0000_0000_0000, "msb_carry");

    // Back-to-back random stream at full rate
    for (int i = 0; i < 1000; i++) begin
      rand_op();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain();

    // Random bubbles and backpressure
    sent = 0;
    for (int i = 0; i < 5000 && sent < 300; i++) begin
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        rand_op();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Fill with the output blocked, hold, then release
    out_ready = 1'b0;
    fill = 0;
    rand_op();
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 10 && in_ready; i++) begin
      step();
      fill++;
      rand_op();
    end
    check("fill_depth", W1'(fill), W1'(S));
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", W1'(in_ready), W1'(0));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", W1'(in_ready), W1'(1));
    step();
    in_valid = 1'b0;
    drain();

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_valid", W1'(out_valid), W1'(0));
    check("flush_sum", W1'(sum), W1'(0));
    single(64'h1, 64'h2, 1'b0, 1'b0, 65'h3, "after_flush");
    for (int i = 0; i < 6; i++) begin
      step();
      check("after_flush_idle", W1'(out_valid), W1'(0));
    end

`ifdef PIPE_ADDER_SUB_EN
    // Subtract mode
    single(64'd5, 64'd7, 1'b0, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFE, "sub_borrow");
    single(64'd7, 64'd5, 1'b0, 1'b1, 65'h1_0000_0000_0000_0002, "sub_noborrow");
    sub = 1'b0;
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
